// File: rtl/escalonador_elevador.sv
// -----------------------------------------------------------------------------
// escalonador_elevador
// SCAN-style elevator scheduler for a single car.
//
// The car keeps travelling in its current direction while requests exist
// beyond it, stops at any requested floor it reaches, and reverses only when
// nothing is pending ahead. Motion and door timing advance on 'tick' (a
// one-clock enable from a slow divided clock). Request latching and stop
// decisions are evaluated on every clock.
//
// Parameters
//   N_ANDARES    number of floors served (0..N_ANDARES-1)
//   T_PORTA      door-open time in ticks (>=1)
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   tick         one-clock pacing pulse for motion and door timing
//   pedido       floor call buttons, one bit per floor
//   andar_atual  current car floor
//   pendentes    registered pending-request vector
//   subindo      car moving up
//   descendo     car moving down
//   porta_aberta door open
//   estado       state code: PARADO=0, SUBINDO=1, DESCENDO=2, PORTA=3
// -----------------------------------------------------------------------------
module escalonador_elevador #(
   parameter int N_ANDARES = 4,
   parameter int T_PORTA   = 3
) (
   input  logic                                            clock,
   input  logic                                            reset,
   input  logic                                            tick,
   input  logic [N_ANDARES-1:0]                            pedido,
   output logic [((N_ANDARES > 1) ? $clog2(N_ANDARES) : 1)-1:0] andar_atual,
   output logic [N_ANDARES-1:0]                            pendentes,
   output logic                                            subindo,
   output logic                                            descendo,
   output logic                                            porta_aberta,
   output logic [1:0]                                      estado
);

   localparam int W = (N_ANDARES > 1) ? $clog2(N_ANDARES) : 1;
   localparam int C = $clog2(T_PORTA + 1);

   typedef enum logic [1:0] {
      PARADO   = 2'd0,
      SUBINDO  = 2'd1,
      DESCENDO = 2'd2,
      PORTA    = 2'd3
   } estado_t;

   estado_t              state_reg, state_next;
   logic [W-1:0]         andar_reg, andar_next;
   logic [N_ANDARES-1:0] pend_reg, pend_next;
   logic [C-1:0]         cnt_reg, cnt_next;
   logic                 dir_reg, dir_next;

   // Per-floor masks relative to the current floor.
   logic [N_ANDARES-1:0] here_mask, above_mask, below_mask;
   logic [N_ANDARES-1:0] clear_mask, porta_mask;
   logic                 pend_here, acima, abaixo, pedido_here;

   genvar gi;
   generate
      for (gi = 0; gi < N_ANDARES; gi++) begin : g_mask
         localparam logic [W-1:0] FLOOR = W'(gi);
         assign here_mask[gi]  = (andar_reg == FLOOR);
         assign above_mask[gi] = (FLOOR > andar_reg);
         assign below_mask[gi] = (FLOOR < andar_reg);
      end
   endgenerate

   assign pend_here   = |(pend_reg & here_mask);
   assign acima       = |(pend_reg & above_mask);
   assign abaixo      = |(pend_reg & below_mask);
   assign pedido_here = |(pedido & here_mask);

   // While the door is open, a call for this floor only holds the door;
   // it never becomes a pending request.
   assign porta_mask = (state_reg == PORTA) ? here_mask : '0;

   always_comb begin
      state_next = state_reg;
      andar_next = andar_reg;
      cnt_next   = cnt_reg;
      dir_next   = dir_reg;
      clear_mask = '0;
      case (state_reg)
         PARADO: begin
            if (pend_here) begin
               state_next = PORTA;
               clear_mask = here_mask;
               cnt_next   = C'(T_PORTA);
            end else if (dir_reg && acima) begin
               state_next = SUBINDO;
            end else if (!dir_reg && abaixo) begin
               state_next = DESCENDO;
            end else if (acima) begin
               state_next = SUBINDO;
               dir_next   = 1'b1;
            end else if (abaixo) begin
               state_next = DESCENDO;
               dir_next   = 1'b0;
            end
         end
         SUBINDO: begin
            // The stop check precedes the tick so a call for the current
            // floor always wins over moving on.
            if (pend_here) begin
               state_next = PORTA;
               clear_mask = here_mask;
               cnt_next   = C'(T_PORTA);
            end else if (!acima) begin
               state_next = PARADO;
            end else if (tick) begin
               andar_next = andar_reg + W'(1);
            end
         end
         DESCENDO: begin
            if (pend_here) begin
               state_next = PORTA;
               clear_mask = here_mask;
               cnt_next   = C'(T_PORTA);
            end else if (!abaixo) begin
               state_next = PARADO;
            end else if (tick) begin
               andar_next = andar_reg - W'(1);
            end
         end
         PORTA: begin
            // A call for this floor reopens/holds the door, even on a tick.
            if (pedido_here) begin
               cnt_next = C'(T_PORTA);
            end else if (tick) begin
               if (cnt_reg <= C'(1)) begin
                  state_next = PARADO;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg - C'(1);
               end
            end
         end
         default: state_next = PARADO;
      endcase
      pend_next = (pend_reg | (pedido & ~porta_mask)) & ~clear_mask;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= PARADO;
         andar_reg <= '0;
         pend_reg  <= '0;
         cnt_reg   <= '0;
         dir_reg   <= 1'b1;
      end else begin
         state_reg <= state_next;
         andar_reg <= andar_next;
         pend_reg  <= pend_next;
         cnt_reg   <= cnt_next;
         dir_reg   <= dir_next;
      end
   end

   assign andar_atual  = andar_reg;
   assign pendentes    = pend_reg;
   assign estado       = state_reg;
   assign subindo      = (state_reg == SUBINDO);
   assign descendo     = (state_reg == DESCENDO);
   assign porta_aberta = (state_reg == PORTA);

endmodule

// File: tb/tb_escalonador_elevador.sv
// -----------------------------------------------------------------------------
// tb_escalonador_elevador
// Directed self-checking bench for escalonador_elevador (N_ANDARES=4,
// T_PORTA=3). Inputs change 1 time unit after a rising edge and outputs are
// sampled at that same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_escalonador_elevador;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       tick  = 1'b0;
   logic [3:0] pedido = 4'b0000;
   logic [1:0] andar_atual;
   logic [3:0] pendentes;
   logic       subindo, descendo, porta_aberta;
   logic [1:0] estado;

   int checks = 0;
   int errors = 0;

   escalonador_elevador #(.N_ANDARES(4), .T_PORTA(3)) dut (
      .clock        (clock),
      .reset        (reset),
      .tick         (tick),
      .pedido       (pedido),
      .andar_atual  (andar_atual),
      .pendentes    (pendentes),
      .subindo      (subindo),
      .descendo     (descendo),
      .porta_aberta (porta_aberta),
      .estado       (estado)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
   endtask

   task automatic press(input logic [3:0] v);
      pedido = v;
      cyc();
      pedido = 4'b0000;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) do_tick();
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_estado", estado, 0);
      check("rst_andar", andar_atual, 0);
      check("rst_pend", pendentes, 0);
      check("rst_flags", {subindo, descendo, porta_aberta}, 0);
      cyc();
      reset = 1'b1;

      // Single request to top floor from floor 0
      press(4'b1000);
      check("t1_latch", pendentes, 8);
      check("t1_still_parado", estado, 0);
      cyc();
      check("t1_subindo", estado, 1);
      check("t1_flag_up", subindo, 1);
      do_tick();
      check("t1_andar1", andar_atual, 1);
      do_tick();
      check("t1_andar2", andar_atual, 2);
      do_tick();
      check("t1_andar3", andar_atual, 3);
      check("t1_moving", estado, 1);
      cyc();
      check("t1_porta", estado, 3);
      check("t1_porta_flag", porta_aberta, 1);
      check("t1_cleared", pendentes, 0);
      ticks(2);
      check("t1_door_2t", estado, 3);
      do_tick();
      check("t1_closed", estado, 0);

      // Return to floor 0
      press(4'b0001);
      cyc();
      check("t2_desc", estado, 2);
      check("t2_flag_down", descendo, 1);
      ticks(3);
      check("t2_andar0", andar_atual, 0);
      cyc();
      check("t2_porta0", estado, 3);
      ticks(3);
      check("t2_parado", estado, 0);

      // SCAN order: moving up past floor 1 toward 3, calls for 0 and 2
      press(4'b1000);
      cyc();
      check("t3_up", estado, 1);
      do_tick();
      check("t3_andar1", andar_atual, 1);
      press(4'b0101);
      check("t3_pend", pendentes, 4'b1101);
      cyc();
      check("t3_still_up", estado, 1);
      do_tick();
      check("t3_andar2", andar_atual, 2);
      cyc();
      check("t3_stop2", estado, 3);
      check("t3_stop2_floor", andar_atual, 2);
      check("t3_pend_a", pendentes, 4'b1001);
      ticks(3);
      cyc();
      check("t3_continue_up", estado, 1);
      do_tick();
      cyc();
      check("t3_stop3", estado, 3);
      check("t3_stop3_floor", andar_atual, 3);
      check("t3_pend_b", pendentes, 4'b0001);
      ticks(3);
      cyc();
      check("t3_reverse", estado, 2);
      ticks(3);
      cyc();
      check("t3_stop0", estado, 3);
      check("t3_stop0_floor", andar_atual, 0);
      check("t3_pend_c", pendentes, 0);
      ticks(3);
      check("t3_parado", estado, 0);

      // Two calls in the same cycle from floor 0
      press(4'b1010);
      check("t4_pend", pendentes, 4'b1010);
      cyc();
      check("t4_up", estado, 1);
      do_tick();
      cyc();
      check("t4_stop1", estado, 3);
      check("t4_stop1_floor", andar_atual, 1);
      ticks(2);
      check("t4_door1_hold", estado, 3);
      do_tick();
      check("t4_door1_close", estado, 0);
      cyc();
      check("t4_up_again", estado, 1);
      ticks(2);
      cyc();
      check("t4_stop3", estado, 3);
      check("t4_stop3_floor", andar_atual, 3);
      ticks(2);
      check("t4_door3_hold", estado, 3);
      do_tick();
      check("t4_done", estado, 0);
      check("t4_pend_zero", pendentes, 0);

      // Go to floor 2 and idle there
      press(4'b0100);
      cyc();
      do_tick();
      cyc();
      check("t5_porta2", estado, 3);
      ticks(3);
      check("t5_idle2", estado, 0);
      check("t5_floor2", andar_atual, 2);

      // Call at current floor while idle, then hold the door
      press(4'b0100);
      cyc();
      check("t5_open_here", estado, 3);
      check("t5_pend_zero", pendentes, 0);
      ticks(2);
      press(4'b0100);
      check("t5_no_latch", pendentes, 0);
      check("t5_held", estado, 3);
      ticks(2);
      check("t5_held_2t", estado, 3);
      do_tick();
      check("t5_closed", estado, 0);

      // No tick for 1000 clocks with a request above
      press(4'b1000);
      cyc();
      check("t6_up", estado, 1);
      for (int k = 0; k < 1000; k++) cyc();
      check("t6_no_move", andar_atual, 2);
      check("t6_still_up", estado, 1);
      do_tick();
      cyc();
      check("t6_porta3", estado, 3);
      ticks(3);

      // Asynchronous reset while descending with pendentes=0101
      press(4'b0101);
      cyc();
      check("t7_desc", estado, 2);
      check("t7_pend", pendentes, 4'b0101);
      #2;
      reset = 1'b0;
      #1;
      check("t7_async_estado", estado, 0);
      check("t7_async_andar", andar_atual, 0);
      check("t7_async_pend", pendentes, 0);
      check("t7_async_flags", {subindo, descendo, porta_aberta}, 0);
      cyc();
      cyc();
      reset = 1'b1;
      ticks(3);
      check("t7_no_motion", andar_atual, 0);
      check("t7_parado", estado, 0);
      press(4'b0010);
      check("t7_first_latch", pendentes, 4'b0010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/escalonador_elevador.md
ESCALONADOR_ELEVADOR -- requirements
Module: escalonador_elevador

Interface
REQ-001 Parameter N_ANDARES, default 4, number of floors served (floors 0..N_ANDARES-1).
REQ-002 Parameter T_PORTA, default 3, door-open duration in tick pulses (>=1).
REQ-003 clock  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tick  input  1  one-clock-wide enable pulse from the slow divided clock; paces motion and door timing.
REQ-006 pedido  input  N_ANDARES  floor call buttons (already debounced); bit i high in any cycle registers a request for floor i.
REQ-007 andar_atual  output  clog2(N_ANDARES)  current car floor.
REQ-008 pendentes  output  N_ANDARES  registered pending-request vector.
REQ-009 subindo  output  1  high while state is SUBINDO.
REQ-010 descendo  output  1  high while state is DESCENDO.
REQ-011 porta_aberta  output  1  high while state is PORTA.
REQ-012 estado  output  2  state code: PARADO=0, SUBINDO=1, DESCENDO=2, PORTA=3.

Function
REQ-013 pendentes[i] shall set on the clock edge after pedido[i] is high; set requests persist until served; no request is ever lost.
REQ-014 Scheduling decisions shall use registered pendentes; a request arriving in cycle n becomes visible to the FSM in cycle n+1.
REQ-015 Internal direction register dir (1=up) shall record last travel direction; "acima"/"abaixo" = any pendentes bit above/below andar_atual.
REQ-016 PARADO: if pendentes[andar_atual] -> PORTA, clear that bit, load door counter with T_PORTA; else if dir and acima -> SUBINDO; else if !dir and abaixo -> DESCENDO; else if acima -> SUBINDO, dir=1; else if abaixo -> DESCENDO, dir=0; else stay. Evaluated every clock, not gated by tick.
REQ-017 SUBINDO: each clock, if pendentes[andar_atual] -> PORTA (clear bit, load counter); else if no acima -> PARADO; else on tick andar_atual increments by 1.
REQ-018 DESCENDO: mirror of REQ-017 with abaixo and decrement.
REQ-019 andar_atual shall never leave 0..N_ANDARES-1; increment at top floor or decrement at floor 0 shall not occur (guaranteed by REQ-017/018 conditions).
REQ-020 Motion latency: one floor per tick; stop decision occurs in the clock after andar_atual updates.
REQ-021 PORTA: counter decrements on each tick; on tick with counter==1 -> PARADO (door closes), counter=0.
REQ-022 PORTA: pedido for andar_atual shall not set pendentes; it reloads counter to T_PORTA (door reopen/hold).
REQ-023 A request for the current floor while SUBINDO/DESCENDO shall stop the car there before the next tick moves it.
REQ-024 Simultaneous tick and pedido: tick processed against registered state; new request latched same edge.
REQ-025 Outputs are registered or decoded directly from registered state; no combinational path from pedido or tick to outputs.

Reset
REQ-026 reset low shall immediately force estado=PARADO, andar_atual=0, pendentes=0, dir=1, door counter=0, all flags low, including mid-motion or mid-door.
REQ-027 After reset release, first request shall be latched on the first rising edge.

Verification
REQ-028 Idle at floor 0, pulse pedido=4'b1000 -> SUBINDO next cycle; andar_atual 1,2,3 on successive ticks; PORTA at floor 3; bit 3 cleared; PARADO after 3 ticks.
REQ-029 Car moving up at floor 1 toward 3, pedido[0] and pedido[2] arrive -> stops at 2, then 3, then reverses to 0 (SCAN order 2,3,0).
REQ-030 Idle at floor 2, pedido[2] -> PORTA next clock, pendentes stays 0; re-press pedido[2] after 2 ticks -> door held 3 more ticks.
REQ-031 pedido[1] and pedido[3] same cycle from floor 0 -> stops at 1 then 3; each door 3 ticks; pendentes=0 at end.
REQ-032 reset asserted while DESCENDO between ticks with pendentes=4'b0101 -> outputs 0/PARADO asynchronously; no motion after release without new pedido.
REQ-033 No tick for 1000 clocks with pending requests above -> andar_atual unchanged, state SUBINDO held.
